// File: rtl/seq_packet_decoder.sv
// Sequence-packet decoder: rebuilds the byte stream from literal/match lanes.
// Ports: seq packet in (valid/strb/ll/ml/offset/delim, ready=pop), literal
// byte stream in (valid/data/ready), byte stream out (valid/data/keep/last,
// ready), sticky o_err for illegal match offsets. clk, rst (sync, active-high).
module seq_packet_decoder #(
    parameter int SEQ_PACKET_SIZE = 4,
    parameter int SEQ_LL_BITS     = 16,
    parameter int SEQ_ML_BITS     = 16,
    parameter int SEQ_OFFSET_BITS = 16,
    parameter int HIST_ADDR_BITS  = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_seq_packet_valid,
    input  logic [SEQ_PACKET_SIZE-1:0]               i_seq_packet_strb,
    input  logic [SEQ_PACKET_SIZE*SEQ_LL_BITS-1:0]   i_seq_packet_ll,
    input  logic [SEQ_PACKET_SIZE*SEQ_ML_BITS-1:0]   i_seq_packet_ml,
    input  logic [SEQ_PACKET_SIZE*SEQ_OFFSET_BITS-1:0] i_seq_packet_offset,
    input  logic [SEQ_PACKET_SIZE-1:0]               i_seq_packet_delim,
    output logic                                     i_seq_packet_ready,
    input  logic                                     i_lit_valid,
    input  logic [7:0]                               i_lit_data,
    output logic                                     i_lit_ready,
    output logic                                     o_valid,
    output logic [7:0]                               o_data,
    output logic                                     o_keep,
    output logic                                     o_last,
    input  logic                                     o_ready,
    output logic                                     o_err
);
    localparam int LW    = (SEQ_PACKET_SIZE > 1) ? $clog2(SEQ_PACKET_SIZE) : 1;
    localparam int PW    = HIST_ADDR_BITS + 1;
    localparam int DEPTH = 1 << HIST_ADDR_BITS;
    localparam logic [PW-1:0] PROD_MAX = {1'b1, {HIST_ADDR_BITS{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LIT, S_MATCH, S_END} state_t;

    state_t state, state_nx;

    logic [LW-1:0]              lane_idx, cur_lane;
    logic [SEQ_LL_BITS-1:0]     ll_cnt;
    logic [SEQ_ML_BITS-1:0]     ml_cnt;
    logic [SEQ_OFFSET_BITS-1:0] cur_off;
    logic                       cur_delim, cur_empty;
    logic [HIST_ADDR_BITS-1:0]  wr_ptr;
    logic [PW-1:0]              prod;
    logic                       m_first, m_bad;
    logic                       m_pend, m_zero, m_fwd;
    logic [7:0]                 m_fwd_data, ram_q;
    logic [7:0]                 hist [DEPTH];

    // Lane pick: lowest set strb at/above lane_idx; rem_any = lanes after cur
    logic           sel_found, rem_any;
    logic [LW-1:0]  sel_lane;

    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        rem_any   = 1'b0;
        for (int i = SEQ_PACKET_SIZE - 1; i >= 0; i--) begin
            if (i_seq_packet_strb[i] && i >= int'(lane_idx)) begin
                sel_found = 1'b1;
                sel_lane  = LW'(i);
            end
            if (i_seq_packet_strb[i] && i > int'(cur_lane))
                rem_any = 1'b1;
        end
    end

    logic [SEQ_LL_BITS-1:0]     sel_ll;
    logic [SEQ_ML_BITS-1:0]     sel_ml;
    logic [SEQ_OFFSET_BITS-1:0] sel_off;
    logic                       sel_delim;

    assign sel_ll    = i_seq_packet_ll[int'(sel_lane)*SEQ_LL_BITS +: SEQ_LL_BITS];
    assign sel_ml    = i_seq_packet_ml[int'(sel_lane)*SEQ_ML_BITS +: SEQ_ML_BITS];
    assign sel_off   = i_seq_packet_offset[int'(sel_lane)*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS];
    assign sel_delim = i_seq_packet_delim[sel_lane];

    logic                      adv, lit_hs, emit_m, wr_now, issue;
    logic                      end_go, bad_now, bad_eff, ll_last;
    logic [HIST_ADDR_BITS-1:0] rd_addr;
    logic [PW-1:0]             prod_eff;
    logic [7:0]                m_byte, wr_data;

    // Output register can take a new beat this cycle
    assign adv     = !o_valid || o_ready;
    assign ll_last = (ll_cnt == SEQ_LL_BITS'(1));
    assign lit_hs  = !rst && (state == S_LIT) && i_lit_valid && adv;
    assign emit_m  = !rst && (state == S_MATCH) && m_pend && adv;
    assign wr_now  = lit_hs || emit_m;

    // The first match read is issued alongside the last literal so the
    // stream keeps one beat per cycle across the literal/match boundary.
    assign issue = !rst && adv && (ml_cnt != '0) &&
                   ((state == S_MATCH) || (lit_hs && ll_last));

    // Issued byte lands one slot past whatever is being written right now
    assign rd_addr  = wr_ptr + HIST_ADDR_BITS'(wr_now)
                      - HIST_ADDR_BITS'(cur_off);
    assign prod_eff = prod + PW'(wr_now);
    assign bad_now  = (cur_off == '0) || (32'(cur_off) > 32'(prod_eff));
    assign bad_eff  = m_first ? bad_now : m_bad;

    assign m_byte  = m_zero ? 8'h00 : (m_fwd ? m_fwd_data : ram_q);
    assign wr_data = lit_hs ? i_lit_data : m_byte;

    assign end_go = !rst && (state == S_END) && (!(cur_empty && cur_delim) || adv);

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (i_seq_packet_valid && sel_found) begin
                    if (sel_ll != '0)
                        state_nx = S_LIT;
                    else if (sel_ml != '0)
                        state_nx = S_MATCH;
                    else
                        state_nx = S_END;
                end
            end
            S_LIT: begin
                if (lit_hs && ll_last)
                    state_nx = (ml_cnt != '0) ? S_MATCH : S_END;
            end
            S_MATCH: begin
                if (emit_m && ml_cnt == '0)
                    state_nx = S_END;
            end
            S_END: begin
                if (end_go)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode
    logic       emit, emit_keep, emit_last, pop, lit_rdy;
    logic [7:0] emit_data;

    always_comb begin
        emit      = 1'b0;
        emit_data = 8'h00;
        emit_keep = 1'b1;
        emit_last = 1'b0;
        pop       = 1'b0;
        lit_rdy   = 1'b0;
        unique case (state)
            S_IDLE: begin
                pop = i_seq_packet_valid && !sel_found;
            end
            S_LIT: begin
                lit_rdy   = adv;
                emit      = lit_hs;
                emit_data = i_lit_data;
                emit_last = cur_delim && ll_last && (ml_cnt == '0);
            end
            S_MATCH: begin
                emit      = emit_m;
                emit_data = m_byte;
                emit_last = cur_delim && (ml_cnt == '0);
            end
            S_END: begin
                emit      = end_go && cur_empty && cur_delim;
                emit_keep = 1'b0;
                emit_last = 1'b1;
                pop       = end_go && !rem_any;
            end
            default: ;
        endcase
    end

    assign i_lit_ready        = lit_rdy && !rst;
    assign i_seq_packet_ready = pop && !rst;

    // State register and sequence datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lane_idx   <= '0;
            cur_lane   <= '0;
            ll_cnt     <= '0;
            ml_cnt     <= '0;
            cur_off    <= '0;
            cur_delim  <= 1'b0;
            cur_empty  <= 1'b0;
            wr_ptr     <= '0;
            prod       <= '0;
            m_first    <= 1'b0;
            m_bad      <= 1'b0;
            m_pend     <= 1'b0;
            m_zero     <= 1'b0;
            m_fwd      <= 1'b0;
            m_fwd_data <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && i_seq_packet_valid) begin
                if (sel_found) begin
                    cur_lane  <= sel_lane;
                    ll_cnt    <= sel_ll;
                    ml_cnt    <= sel_ml;
                    cur_off   <= sel_off;
                    cur_delim <= sel_delim;
                    cur_empty <= (sel_ll == '0) && (sel_ml == '0);
                    m_first   <= 1'b1;
                end else begin
                    lane_idx <= '0;
                end
            end
            if (lit_hs)
                ll_cnt <= ll_cnt - SEQ_LL_BITS'(1);
            if (issue) begin
                ml_cnt     <= ml_cnt - SEQ_ML_BITS'(1);
                m_first    <= 1'b0;
                m_bad      <= bad_eff;
                m_zero     <= bad_eff;
                // Same-cycle write to the read address: RAM returns stale data
                m_fwd      <= wr_now && (rd_addr == wr_ptr);
                m_fwd_data <= wr_data;
            end
            if (issue)
                m_pend <= 1'b1;
            else if (emit_m)
                m_pend <= 1'b0;
            if (wr_now) begin
                wr_ptr <= wr_ptr + HIST_ADDR_BITS'(1);
                if (prod != PROD_MAX)
                    prod <= prod + PW'(1);
            end
            if (end_go) begin
                if (cur_delim)
                    prod <= '0;
                lane_idx <= rem_any ? cur_lane + LW'(1) : '0;
            end
        end
    end

    // History RAM; ram_q only loads on issue so it holds through stalls
    always_ff @(posedge clk) begin
        if (wr_now)
            hist[wr_ptr] <= wr_data;
        if (issue)
            ram_q <= hist[rd_addr];
    end

    // Registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= 8'h00;
            o_keep  <= 1'b0;
            o_last  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (adv) begin
                o_valid <= emit;
                o_data  <= emit ? emit_data : 8'h00;
                o_keep  <= emit && emit_keep;
                o_last  <= emit && emit_last;
            end
            if (issue && m_first && bad_now)
                o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_packet_decoder.sv
// Testbench for seq_packet_decoder: scoreboard of expected output beats,
// literal stream driver, ready pattern driver, scenario tasks.
module tb_seq_packet_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_seq_packet_valid;
    logic [3:0]  i_seq_packet_strb;
    logic [63:0] i_seq_packet_ll;
    logic [63:0] i_seq_packet_ml;
    logic [63:0] i_seq_packet_offset;
    logic [3:0]  i_seq_packet_delim;
    logic        i_seq_packet_ready;
    logic        i_lit_valid;
    logic [7:0]  i_lit_data;
    logic        i_lit_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_keep;
    logic        o_last;
    logic        o_ready;
    logic        o_err;

    always #5 clk = ~clk;

    seq_packet_decoder dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_seq_packet_valid  (i_seq_packet_valid),
        .i_seq_packet_strb   (i_seq_packet_strb),
        .i_seq_packet_ll     (i_seq_packet_ll),
        .i_seq_packet_ml     (i_seq_packet_ml),
        .i_seq_packet_offset (i_seq_packet_offset),
        .i_seq_packet_delim  (i_seq_packet_delim),
        .i_seq_packet_ready  (i_seq_packet_ready),
        .i_lit_valid         (i_lit_valid),
        .i_lit_data          (i_lit_data),
        .i_lit_ready         (i_lit_ready),
        .o_valid             (o_valid),
        .o_data              (o_data),
        .o_keep              (o_keep),
        .o_last              (o_last),
        .o_ready             (o_ready),
        .o_err               (o_err)
    );

    int         tests = 0;
    int         fails = 0;
    logic [9:0] exp_q[$];
    logic [7:0] lit_q[$];
    int         beat_cyc[$];
    int         pop_cnt = 0;
    int         cyc = 0;
    bit         sb_off = 1'b0;
    int         rdy_mode = 0;

    // expected beat = {keep, last, data}
    function automatic void push_exp(logic keep, logic last, logic [7:0] d);
        exp_q.push_back({keep, last, d});
    endfunction

    task automatic lit_driver();
        logic hs;
        forever begin
            @(negedge clk);
            hs = i_lit_valid && i_lit_ready;
            @(posedge clk);
            #1;
            if (hs && lit_q.size() > 0)
                void'(lit_q.pop_front());
            i_lit_valid = (lit_q.size() > 0);
            i_lit_data  = (lit_q.size() > 0) ? lit_q[0] : 8'h00;
        end
    endtask

    task automatic rdy_driver();
        logic tog = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                o_ready = 1'b1;
                tog     = 1'b1;
            end else begin
                o_ready = tog;
                tog     = ~tog;
            end
        end
    endtask

    task automatic monitor();
        logic       stalled = 1'b0;
        logic [9:0] held = '0;
        logic [9:0] got;
        logic [9:0] want;
        forever begin
            @(negedge clk);
            cyc++;
            if (i_seq_packet_ready)
                pop_cnt++;
            got = {o_keep, o_last, o_data};
            if (!rst && !sb_off) begin
                if (stalled) begin
                    tests++;
                    if (!o_valid || got !== held) begin
                        fails++;
                        $display("FAIL stall_hold: got v=%b %h, required v=1 %h",
                                 o_valid, got, held);
                    end
                end
                if (o_valid && o_ready) begin
                    tests++;
                    beat_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL beat: got %h, required no beat", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            fails++;
                            $display("FAIL beat: got {keep,last,data}=%h, required %h",
                                     got, want);
                        end
                    end
                end
            end
            stalled = !rst && o_valid && !o_ready;
            held    = got;
        end
    endtask

    task automatic drive_pkt(logic [3:0] strb, logic [63:0] ll, logic [63:0] ml,
                             logic [63:0] off, logic [3:0] delim);
        i_seq_packet_strb   = strb;
        i_seq_packet_ll     = ll;
        i_seq_packet_ml     = ml;
        i_seq_packet_offset = off;
        i_seq_packet_delim  = delim;
        i_seq_packet_valid  = 1'b1;
    endtask

    task automatic send_pkt(string name, logic [3:0] strb, logic [63:0] ll,
                            logic [63:0] ml, logic [63:0] off, logic [3:0] delim);
        int n = 0;
        @(posedge clk);
        #1;
        drive_pkt(strb, ll, ml, off, delim);
        do begin
            @(negedge clk);
            n++;
        end while (!i_seq_packet_ready && n < 3000);
        tests++;
        if (!i_seq_packet_ready) begin
            fails++;
            $display("FAIL %s pop: got no pop in %0d cycles, required pop", name, n);
        end
        @(posedge clk);
        #1;
        i_seq_packet_valid = 1'b0;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: got %0d beats missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({o_valid, o_keep, o_last, o_err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got v/k/l/e=%b%b%b%b, required 0000",
                     o_valid, o_keep, o_last, o_err);
        end
        tests++;
        if (o_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %h, required 00", o_data);
        end
        tests++;
        if ({i_lit_ready, i_seq_packet_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready: got lit/pkt=%b%b, required 00",
                     i_lit_ready, i_seq_packet_ready);
        end
    endtask

    task automatic test_literals();
        int p0 = pop_cnt;
        lit_q.push_back("A");
        lit_q.push_back("B");
        lit_q.push_back("C");
        push_exp(1, 0, "A");
        push_exp(1, 0, "B");
        push_exp(1, 1, "C");
        send_pkt("literals", 4'b0001, 64'd3, 64'd0, 64'd0, 4'b0001);
        drain("literals");
        tests++;
        if (pop_cnt - p0 != 1) begin
            fails++;
            $display("FAIL literals_pops: got %0d, required 1", pop_cnt - p0);
        end
    endtask

    task automatic run_rle(string name);
        lit_q.push_back("x");
        for (int i = 0; i < 6; i++)
            push_exp(1, i == 5, "x");
        beat_cyc.delete();
        send_pkt(name, 4'b0001, 64'd1, 64'd5, 64'd1, 4'b0001);
        drain(name);
    endtask

    task automatic test_rle();
        run_rle("rle");
        tests++;
        if (beat_cyc.size() != 6 || beat_cyc[5] - beat_cyc[0] != 5) begin
            fails++;
            $display("FAIL rle_rate: got %0d beats over %0d cycles, required 6 over 5",
                     beat_cyc.size(),
                     beat_cyc.size() > 1 ? beat_cyc[beat_cyc.size()-1] - beat_cyc[0] : 0);
        end
        tests++;
        if (o_err !== 1'b0) begin
            fails++;
            $display("FAIL rle_err: got %b, required 0", o_err);
        end
    endtask

    task automatic test_multi_lane();
        int p0 = pop_cnt;
        logic [7:0] pat [7];
        pat = '{"a", "b", "a", "b", "a", "b", "a"};
        lit_q.push_back("a");
        lit_q.push_back("b");
        for (int i = 0; i < 7; i++)
            push_exp(1, i == 6, pat[i]);
        send_pkt("multi_lane", 4'b0101,
                 {16'd9, 16'd0, 16'd7, 16'd2},
                 {16'd9, 16'd3, 16'd7, 16'd2},
                 {16'd1, 16'd4, 16'd1, 16'd2},
                 4'b1110);
        drain("multi_lane");
        tests++;
        if (pop_cnt - p0 != 1) begin
            fails++;
            $display("FAIL multi_lane_pops: got %0d, required 1", pop_cnt - p0);
        end
        tests++;
        if (o_err !== 1'b0) begin
            fails++;
            $display("FAIL multi_lane_err: got %b, required 0", o_err);
        end
    endtask

    task automatic test_empty_strb();
        int p0 = pop_cnt;
        send_pkt("empty_strb", 4'b0000, 64'd5, 64'd5, 64'd1, 4'b1111);
        drain("empty_strb");
        tests++;
        if (pop_cnt - p0 != 1) begin
            fails++;
            $display("FAIL empty_strb_pops: got %0d, required 1", pop_cnt - p0);
        end
    endtask

    task automatic test_bad_offset();
        lit_q.push_back("x");
        lit_q.push_back("y");
        lit_q.push_back("z");
        push_exp(1, 0, "x");
        push_exp(1, 0, "y");
        push_exp(1, 0, "z");
        push_exp(1, 0, 8'h00);
        push_exp(1, 1, 8'h00);
        send_pkt("bad_offset", 4'b0001, 64'd3, 64'd2, 64'd5, 4'b0001);
        drain("bad_offset");
        tests++;
        if (o_err !== 1'b1) begin
            fails++;
            $display("FAIL bad_offset_err: got %b, required 1", o_err);
        end
        push_exp(0, 1, 8'h00);
        send_pkt("empty_delim", 4'b0001, 64'd0, 64'd0, 64'd0, 4'b0001);
        drain("empty_delim");
        tests++;
        if (o_err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got %b, required 1", o_err);
        end
    endtask

    task automatic test_stall();
        rdy_mode = 1;
        run_rle("stall");
        tests++;
        if (beat_cyc.size() != 6) begin
            fails++;
            $display("FAIL stall_beats: got %0d, required 6", beat_cyc.size());
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int p0;
        sb_off = 1'b1;
        lit_q.push_back("x");
        @(posedge clk);
        #1;
        drive_pkt(4'b0001, 64'd1, 64'd200, 64'd1, 4'b0001);
        repeat (12) @(posedge clk);
        #1;
        p0 = pop_cnt;
        rst = 1'b1;
        i_seq_packet_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({o_valid, o_err, i_lit_ready} !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset: got v/err/lit_rdy=%b%b%b, required 000",
                     o_valid, o_err, i_lit_ready);
        end
        tests++;
        if (pop_cnt != p0) begin
            fails++;
            $display("FAIL mid_reset_pop: got %0d pops, required 0", pop_cnt - p0);
        end
        lit_q.delete();
        exp_q.delete();
        sb_off = 1'b0;
        // Count restarted at 0: offset 2 after one byte must be illegal
        lit_q.push_back("r");
        push_exp(1, 0, "r");
        push_exp(1, 0, 8'h00);
        send_pkt("post_reset_cnt", 4'b0001, 64'd1, 64'd1, 64'd2, 4'b0000);
        drain("post_reset_cnt");
        tests++;
        if (o_err !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_err: got %b, required 1", o_err);
        end
        lit_q.push_back("q");
        push_exp(1, 1, "q");
        send_pkt("post_reset", 4'b0001, 64'd1, 64'd0, 64'd0, 4'b0001);
        drain("post_reset");
    endtask

    initial begin
        rst                 = 1'b1;
        o_ready             = 1'b1;
        i_lit_valid         = 1'b0;
        i_lit_data          = 8'h00;
        i_seq_packet_valid  = 1'b0;
        i_seq_packet_strb   = '0;
        i_seq_packet_ll     = '0;
        i_seq_packet_ml     = '0;
        i_seq_packet_offset = '0;
        i_seq_packet_delim  = '0;
        fork
            lit_driver();
            rdy_driver();
            monitor();
        join_none
        test_reset();
        test_literals();
        test_rle();
        test_multi_lane();
        test_empty_strb();
        test_bad_offset();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_packet_decoder.md
Name: seq_packet_decoder

Overview:
- Decompression-side counterpart of the compressor's sequence-packet output.
- Consumes sequence packets (literal length, match length, offset, delim per lane) plus a raw literal byte stream, and reconstructs the original byte stream at 1 byte/cycle.
- Keeps a circular history RAM for match copies.
- Sits after the packet sink (DMA/FIFO) in the decompression and verification datapath.

Parameters:
SEQ_PACKET_SIZE, 4, lanes per sequence packet
SEQ_LL_BITS, 16, literal-length field width
SEQ_ML_BITS, 16, match-length field width
SEQ_OFFSET_BITS, 16, offset field width
HIST_ADDR_BITS, 16, log2 of history RAM depth in bytes (window = 2^HIST_ADDR_BITS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_seq_packet_valid  in  1  packet valid
i_seq_packet_strb  in  SEQ_PACKET_SIZE  lane valid mask, lane 0 first
i_seq_packet_ll  in  SEQ_PACKET_SIZE*SEQ_LL_BITS  literal length per lane
i_seq_packet_ml  in  SEQ_PACKET_SIZE*SEQ_ML_BITS  match length per lane
i_seq_packet_offset  in  SEQ_PACKET_SIZE*SEQ_OFFSET_BITS  match distance per lane
i_seq_packet_delim  in  SEQ_PACKET_SIZE  lane ends a block
i_seq_packet_ready  out  1  packet accepted (pop)
i_lit_valid  in  1  literal byte valid
i_lit_data  in  8  literal byte
i_lit_ready  out  1  literal byte consumed
o_valid  out  1  output beat valid
o_data  out  8  reconstructed byte
o_keep  out  1  1 = o_data is a real byte; 0 = empty delimiter beat
o_last  out  1  final beat of a delimited block
o_ready  in  1  downstream ready
o_err  out  1  sticky illegal-offset flag

Behaviour:
- Reset, synchronous on rst=1:
  - All outputs are 0.
  - FSM returns to IDLE and the lane index clears.
  - The history write pointer and the produced count clear.
  - History RAM contents are not cleared.
  - Reset mid-sequence abandons the sequence; the partially consumed packet is not popped.
- FSM IDLE:
  - Wait for i_seq_packet_valid, then select the lowest set strb lane at or above the lane index.
  - Latch that lane's ll, ml, offset and delim.
  - Go to LIT if ll>0, else MATCH if ml>0, else END.
  - strb=0: pop the packet immediately with no output.
- FSM LIT:
  - i_lit_ready=1 only when the output stage can accept a beat.
  - On each literal handshake, emit the byte, write it into history, and decrement the ll counter.
  - At 0, go to MATCH if ml>0, else END.
- FSM MATCH:
  - Issue a history read at address wr_ptr - offset (modulo 2^HIST_ADDR_BITS); data returns 1 cycle later.
  - Emit the byte, write it, and decrement ml. Go to END at 0.
  - Read/write collision on the same address in the same cycle (offset=1, or any run shorter than the pipeline) forwards the write data. A repeating pattern must be reproduced exactly.
- FSM END:
  - If delim: o_last is set on the last emitted beat of this sequence.
  - If the sequence has ll=ml=0 with delim, emit one beat with o_keep=0, o_last=1, o_data=0.
  - After the delim beat is accepted, clear the produced count.
  - Advance to the next set strb lane. If none remain, pulse i_seq_packet_ready for 1 cycle (pop) and reset the lane index.
  - Return to IDLE.
- Produced count:
  - Counts bytes since the last delim and saturates at 2^HIST_ADDR_BITS.
  - offset=0, or offset > produced count, sets o_err (sticky until rst).
  - The match still runs ml beats, each emitting 0x00 and writing 0x00 into history.
- Output stage:
  - Registered.
  - While o_valid=1 and o_ready=0, o_data, o_keep and o_last hold stable.
  - No literal is consumed, no read issued and no counter advanced while stalled.
  - A pending RAM read result is held in a skid register.
  - Throughput is 1 beat/cycle with o_ready=1; first byte latency is 2 cycles after packet acceptance into IDLE.
- Widths:
  - ll and ml counters are full-width. ll=2^SEQ_LL_BITS-1 must complete without wrap.
  - wr_ptr wraps modulo 2^HIST_ADDR_BITS.
- Literal underflow: i_lit_valid=0 in LIT stalls the FSM; this is not an error.

Test Plan:
- Packet strb=0001, lane0 ll=3 ml=0 delim=1, literals 'A','B','C' -> o_data A,B,C with o_keep=1; o_last=1 on C only; one i_seq_packet_ready pulse.
- ll=1 'x', ml=5 offset=1 -> bytes "xxxxxx", 6 beats in 6 consecutive cycles with o_ready=1, o_err=0.
- strb=0101: lane0 ll=2 "ab" ml=2 off=2; lane2 ll=0 ml=3 off=4 delim=1 -> "abababa", o_last on the final 'a'; lane1 and lane3 ignored.
- After delim, ll=3 "xyz" ml=2 off=5 -> "xyz",0x00,0x00 and o_err=1 that stays 1. Repeat with lane ll=0 ml=0 delim=1 -> single beat o_keep=0 o_last=1.
- Repeat the offset=1 case with o_ready toggling 1,0,1,0 -> identical byte sequence, no drop or duplicate, o_data stable during every stall cycle.
- Assert rst for 1 cycle mid-MATCH -> next cycle o_valid=0, o_err=0, i_lit_ready=0; a fresh ll=1 ml=0 delim packet then decodes correctly with produced count restarted.
